// File: rtl/clock_set_ctrl.sv
// Front-panel key sequencer for the digital clock: time/alarm editing,
// counter load strobes, alarm arming and the timed alarm ring.
//
// state    | meaning
// ---------+---------------------------------------------------
// RUN      | normal display, ok toggles alarm arming
// SET_HOUR | editing the live hour, ok loads the hour counter
// SET_MIN  | editing the live minute, ok loads the minute counter
// SET_SEC  | editing the live second, ok loads the second counter
// AL_HOUR  | editing the alarm hour, ok stores it and arms the alarm
// AL_MIN   | editing the alarm minute, ok stores it and arms the alarm
// RING     | alarm sounding until dismissed or RING_SEC ticks elapse
module clock_set_ctrl #(
  parameter int unsigned RING_SEC = 60,
  parameter int unsigned HOUR_MAX = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic       key_ok,
  input  logic       sec_tick,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [2:0] mode,
  output logic [5:0] set_val,
  output logic       set_hour,
  output logic       set_min,
  output logic       set_sec,
  output logic [2:0] alarm_set,
  output logic [5:0] alarm_val,
  output logic [4:0] al_hour,
  output logic [5:0] al_min,
  output logic       alarm_en,
  output logic       ring
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    SET_HOUR = 3'd1,
    SET_MIN  = 3'd2,
    SET_SEC  = 3'd3,
    AL_HOUR  = 3'd4,
    AL_MIN   = 3'd5,
    RING     = 3'd6,
    ILLEGAL  = 3'd7
  } state_e;

  localparam logic [5:0] HOUR_MAX_W = 6'(HOUR_MAX);
  localparam logic [5:0] FIELD_MAX_W = 6'd59;
  localparam logic [5:0] RING_SEC_W = 6'(RING_SEC);

  state_e     state_q;
  logic [3:0] key_q, key_prev_q;
  logic [5:0] edit_q;
  logic [5:0] ring_cnt_q;
  logic       set_hour_q, set_min_q, set_sec_q;
  logic [2:0] alarm_set_q;
  logic [4:0] al_hour_q;
  logic [5:0] al_min_q;
  logic       alarm_en_q;
  logic       ring_q;

  logic       ev_mode, ev_inc, ev_dec, ev_ok;
  logic       step_up, step_dn, step;
  logic       is_hour_field;
  logic [5:0] edit_max;
  logic [5:0] edit_step;
  logic [5:0] ring_cnt_inc;
  logic       trigger;

  // key_q holds {ok, dec, inc, mode}; an event is a rise of the registered level
  assign ev_mode = key_q[0] & ~key_prev_q[0];
  assign ev_inc  = key_q[1] & ~key_prev_q[1];
  assign ev_dec  = key_q[2] & ~key_prev_q[2];
  assign ev_ok   = key_q[3] & ~key_prev_q[3];

  assign step_up = ev_inc & ~ev_dec;
  assign step_dn = ev_dec & ~ev_inc;
  assign step    = step_up | step_dn;

  assign is_hour_field = (state_q == SET_HOUR) || (state_q == AL_HOUR);
  assign edit_max      = is_hour_field ? HOUR_MAX_W : FIELD_MAX_W;

  always_comb begin
    edit_step = edit_q;
    if (step_up) begin
      edit_step = (edit_q >= edit_max) ? 6'd0 : edit_q + 6'd1;
    end else if (step_dn) begin
      edit_step = (edit_q == 6'd0) ? edit_max : edit_q - 6'd1;
    end
  end

  assign ring_cnt_inc = ring_cnt_q + 6'd1;

  assign trigger = (state_q == RUN) && alarm_en_q && sec_tick &&
                   (cur_hour == al_hour_q) && (cur_min == al_min_q) &&
                   (cur_sec == 6'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      key_q       <= 4'b0;
      key_prev_q  <= 4'b0;
      edit_q      <= 6'd0;
      ring_cnt_q  <= 6'd0;
      set_hour_q  <= 1'b0;
      set_min_q   <= 1'b0;
      set_sec_q   <= 1'b0;
      alarm_set_q <= 3'b000;
      al_hour_q   <= 5'd0;
      al_min_q    <= 6'd0;
      alarm_en_q  <= 1'b0;
      ring_q      <= 1'b0;
    end else begin
      key_q       <= {key_ok, key_dec, key_inc, key_mode};
      key_prev_q  <= key_q;
      set_hour_q  <= 1'b0;
      set_min_q   <= 1'b0;
      set_sec_q   <= 1'b0;
      alarm_set_q <= 3'b000;

      case (state_q)
        RUN: begin
          if (trigger) begin
            state_q    <= RING;
            ring_q     <= 1'b1;
            ring_cnt_q <= 6'd0;
          end else if (ev_mode) begin
            state_q <= SET_HOUR;
            edit_q  <= {1'b0, cur_hour};
          end else if (ev_ok) begin
            alarm_en_q <= ~alarm_en_q;
          end
        end

        SET_HOUR: begin
          if (ev_mode) begin
            state_q <= SET_MIN;
            edit_q  <= cur_min;
          end else if (ev_ok) begin
            state_q    <= RUN;
            set_hour_q <= 1'b1;
          end else if (step) begin
            edit_q <= edit_step;
          end
        end

        SET_MIN: begin
          if (ev_mode) begin
            state_q <= SET_SEC;
            edit_q  <= cur_sec;
          end else if (ev_ok) begin
            state_q   <= RUN;
            set_min_q <= 1'b1;
          end else if (step) begin
            edit_q <= edit_step;
          end
        end

        SET_SEC: begin
          if (ev_mode) begin
            state_q     <= AL_HOUR;
            edit_q      <= {1'b0, al_hour_q};
            alarm_set_q <= 3'b001;
          end else if (ev_ok) begin
            state_q   <= RUN;
            set_sec_q <= 1'b1;
          end else if (step) begin
            edit_q <= edit_step;
          end
        end

        // alarm_set[0] stays high through the store-strobe cycle in RUN
        AL_HOUR: begin
          if (ev_mode) begin
            state_q     <= AL_MIN;
            edit_q      <= al_min_q;
            alarm_set_q <= 3'b001;
          end else if (ev_ok) begin
            state_q     <= RUN;
            al_hour_q   <= edit_q[4:0];
            alarm_en_q  <= 1'b1;
            alarm_set_q <= 3'b101;
          end else begin
            alarm_set_q <= 3'b001;
            if (step) edit_q <= edit_step;
          end
        end

        AL_MIN: begin
          if (ev_mode) begin
            state_q <= RUN;
          end else if (ev_ok) begin
            state_q     <= RUN;
            al_min_q    <= edit_q;
            alarm_en_q  <= 1'b1;
            alarm_set_q <= 3'b011;
          end else begin
            alarm_set_q <= 3'b001;
            if (step) edit_q <= edit_step;
          end
        end

        RING: begin
          if (ev_mode || ev_ok) begin
            state_q <= RUN;
            ring_q  <= 1'b0;
          end else if (sec_tick) begin
            ring_cnt_q <= ring_cnt_inc;
            if (ring_cnt_inc >= RING_SEC_W) begin
              state_q <= RUN;
              ring_q  <= 1'b0;
            end
          end
        end

        default: begin
          state_q <= RUN;
          ring_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mode      = state_q;
  assign set_val   = edit_q;
  assign alarm_val = edit_q;
  assign set_hour  = set_hour_q;
  assign set_min   = set_min_q;
  assign set_sec   = set_sec_q;
  assign alarm_set = alarm_set_q;
  assign al_hour   = al_hour_q;
  assign al_min    = al_min_q;
  assign alarm_en  = alarm_en_q;
  assign ring      = ring_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: editing, wrap, alarm store, ring and reset.
module tb_clock_set_ctrl;

  localparam int K_MODE = 0;
  localparam int K_INC  = 1;
  localparam int K_DEC  = 2;
  localparam int K_OK   = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] keys;
  logic       sec_tick;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic [2:0] mode;
  logic [5:0] set_val;
  logic       set_hour;
  logic       set_min;
  logic       set_sec;
  logic [2:0] alarm_set;
  logic [5:0] alarm_val;
  logic [4:0] al_hour;
  logic [5:0] al_min;
  logic       alarm_en;
  logic       ring;

  int vectors = 0;
  int miscompares = 0;

  clock_set_ctrl #(.RING_SEC(60), .HOUR_MAX(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_mode  (keys[K_MODE]),
    .key_inc   (keys[K_INC]),
    .key_dec   (keys[K_DEC]),
    .key_ok    (keys[K_OK]),
    .sec_tick  (sec_tick),
    .cur_hour  (cur_hour),
    .cur_min   (cur_min),
    .cur_sec   (cur_sec),
    .mode      (mode),
    .set_val   (set_val),
    .set_hour  (set_hour),
    .set_min   (set_min),
    .set_sec   (set_sec),
    .alarm_set (alarm_set),
    .alarm_val (alarm_val),
    .al_hour   (al_hour),
    .al_min    (al_min),
    .alarm_en  (alarm_en),
    .ring      (ring)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full press: level high two cycles (detect + act), then released.
  task automatic press(input int k);
    keys[k] = 1'b1;
    tick();
    tick();
    keys[k] = 1'b0;
    tick();
  endtask

  task automatic pulse_tick();
    sec_tick = 1'b1;
    tick();
    sec_tick = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    keys     = 4'b0;
    sec_tick = 1'b0;
    cur_hour = 5'd10;
    cur_min  = 6'd58;
    cur_sec  = 6'd20;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    check("rst_mode", mode, 0);
    check("rst_strobes", {set_hour, set_min, set_sec}, 0);
    check("rst_alarm_set", alarm_set, 0);
    check("rst_al_hour", al_hour, 0);
    check("rst_al_min", al_min, 0);
    check("rst_ring", ring, 0);
    check("rst_alarm_en", alarm_en, 0);
    check("rst_set_val", set_val, 0);

    // Minute edit 58 + 3 wraps to 1, then load
    press(K_MODE);
    check("enter_set_hour", mode, 1);
    check("load_cur_hour", set_val, 10);
    press(K_MODE);
    check("enter_set_min", mode, 2);
    check("load_cur_min", set_val, 58);
    for (int i = 0; i < 3; i++) press(K_INC);
    check("min_wrap_val", set_val, 1);
    check("no_early_strobe", set_min, 0);
    keys[K_OK] = 1'b1;
    tick();
    check("strobe_latency", set_min, 0);
    tick();
    check("set_min_strobe", set_min, 1);
    check("set_min_mode_run", mode, 0);
    check("set_min_value", set_val, 1);
    check("other_strobes", {set_hour, set_sec}, 0);
    keys[K_OK] = 1'b0;
    tick();
    check("set_min_one_cycle", set_min, 0);

    // Hour wrap both directions, inc+dec cancel
    cur_hour = 5'd0;
    press(K_MODE);
    check("hour_edit_zero", set_val, 0);
    press(K_DEC);
    check("hour_dec_wrap", set_val, 23);
    press(K_INC);
    check("hour_inc_wrap", set_val, 0);
    press(K_INC);
    press(K_INC);
    check("hour_inc_2", set_val, 2);
    keys[K_INC] = 1'b1;
    keys[K_DEC] = 1'b1;
    tick();
    tick();
    keys[K_INC] = 1'b0;
    keys[K_DEC] = 1'b0;
    tick();
    check("inc_dec_cancel", set_val, 2);
    check("still_set_hour", mode, 1);

    // Leave by mode: edit discarded, no strobe; into AL_HOUR
    cur_sec = 6'd45;
    press(K_MODE);
    press(K_MODE);
    check("set_sec_loads", set_val, 45);
    press(K_MODE);
    check("enter_al_hour", mode, 4);
    check("al_hour_load", alarm_val, 0);
    check("show_alarm", alarm_set, 3'b001);
    check("no_hour_strobe", set_hour, 0);
    for (int i = 0; i < 7; i++) press(K_INC);
    check("al_hour_edit", alarm_val, 7);
    keys[K_OK] = 1'b1;
    tick();
    tick();
    check("al_hour_strobe", alarm_set, 3'b101);
    check("al_hour_stored", al_hour, 7);
    check("alarm_armed", alarm_en, 1);
    check("al_hour_to_run", mode, 0);
    keys[K_OK] = 1'b0;
    tick();
    check("al_hour_strobe_end", alarm_set, 3'b000);

    // Alarm minute = 30
    for (int i = 0; i < 5; i++) press(K_MODE);
    check("enter_al_min", mode, 5);
    check("al_hour_reload", al_hour, 7);
    for (int i = 0; i < 30; i++) press(K_INC);
    check("al_min_edit", alarm_val, 30);
    keys[K_OK] = 1'b1;
    tick();
    tick();
    check("al_min_strobe", alarm_set, 3'b011);
    check("al_min_stored", al_min, 30);
    check("al_min_to_run", mode, 0);
    keys[K_OK] = 1'b0;
    tick();
    check("al_min_strobe_end", alarm_set, 3'b000);

    // ok in RUN toggles arming
    press(K_OK);
    check("disarm", alarm_en, 0);
    press(K_OK);
    check("rearm", alarm_en, 1);

    // Ring then timeout after 60 ticks
    cur_hour = 5'd7;
    cur_min  = 6'd30;
    cur_sec  = 6'd0;
    pulse_tick();
    check("ring_start", ring, 1);
    check("ring_mode", mode, 6);
    for (int i = 0; i < 59; i++) begin
      pulse_tick();
      tick();
    end
    check("ring_59", ring, 1);
    pulse_tick();
    check("ring_timeout", ring, 0);
    check("ring_timeout_mode", mode, 0);
    cur_sec = 6'd1;
    tick();

    // Ring, 5 ticks, then ok dismisses without disarming
    cur_sec = 6'd0;
    pulse_tick();
    check("ring_again", ring, 1);
    cur_sec = 6'd1;
    for (int i = 0; i < 5; i++) begin
      pulse_tick();
      tick();
    end
    press(K_INC);
    check("inc_ignored_ring", ring, 1);
    keys[K_OK] = 1'b1;
    tick();
    check("ok_detect", ring, 1);
    tick();
    check("ok_dismiss", ring, 0);
    check("ok_dismiss_mode", mode, 0);
    check("still_armed", alarm_en, 1);
    keys[K_OK] = 1'b0;
    tick();

    // mode in RING dismisses, does not enter SET_HOUR
    cur_sec = 6'd0;
    pulse_tick();
    check("ring_third", ring, 1);
    cur_sec = 6'd1;
    press(K_MODE);
    check("mode_dismiss_mode", mode, 0);
    check("mode_dismiss_ring", ring, 0);

    // Reset with ok pending in SET_MIN
    cur_sec = 6'd5;
    press(K_MODE);
    press(K_MODE);
    check("pre_reset_mode", mode, 2);
    keys[K_OK] = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_mode", mode, 0);
    check("async_rst_al", {al_hour, al_min}, 0);
    check("async_rst_en", alarm_en, 0);
    check("async_rst_set_min", set_min, 0);
    tick();
    check("rst_no_strobe", set_min, 0);
    keys[K_OK] = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_set_min", set_min, 0);
    check("post_rst_mode", mode, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Front-panel controller for the digital clock.
- Decodes mode, inc, dec and ok keys and sequences set/load strobes into the hour, minute and second counters and the alarm registers.
- Drives `alarm_set` so the minute and hour blocks switch their displays to alarm values.
- Fires and times out the alarm ring.
- Sits between the debounced key inputs and the clock counter blocks. Everything runs in the `clk` domain.

Parameters:
- RING_SEC, 60, length of the alarm ring in `sec_tick` pulses (1..63).
- HOUR_MAX, 23, top value of the hour field; hour wraps HOUR_MAX↔0.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- key_mode  in  1  debounced level, mode key
- key_inc  in  1  debounced level, increment key
- key_dec  in  1  debounced level, decrement key
- key_ok  in  1  debounced level, confirm/dismiss key
- sec_tick  in  1  one-`clk` pulse per second
- cur_hour  in  5  live hour count
- cur_min  in  6  live minute count
- cur_sec  in  6  live second count
- mode  out  3  current state code
- set_val  out  6  value for counter load (hour in bits 4:0, bit 5 = 0)
- set_hour  out  1  one-cycle load strobe, hour counter
- set_min  out  1  one-cycle load strobe, minute counter
- set_sec  out  1  one-cycle load strobe, second counter
- alarm_set  out  3  bit0 = show alarm, bit1 = load alarm minute, bit2 = load alarm hour
- alarm_val  out  6  value for alarm load
- al_hour  out  5  stored alarm hour
- al_min  out  6  stored alarm minute
- alarm_en  out  1  alarm armed
- ring  out  1  alarm sounding

Behaviour:
- Reset values: all outputs 0. `mode` = RUN, edit register = 0, ring counter = 0.
- Key edge detection:
  - Each key is registered once. An event is the rising edge of that registered level: exactly one event per press, 1-cycle detect latency.
  - Holding a key produces no repeats.
- Event priority within a cycle: mode > ok > inc/dec. inc and dec in the same cycle cancel; no change.
- State codes: RUN=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3, AL_HOUR=4, AL_MIN=5, RING=6. Code 7 returns to RUN on the next clock.
- Mode key cycles RUN→SET_HOUR→SET_MIN→SET_SEC→AL_HOUR→AL_MIN→RUN.
  - Leaving a set or alarm state by the mode key discards the edit; no strobe is issued.
- Edit register loading, on the cycle the state is entered:
  - SET_HOUR loads `cur_hour`.
  - SET_MIN loads `cur_min`.
  - SET_SEC loads `cur_sec`.
  - AL_HOUR loads `al_hour`.
  - AL_MIN loads `al_min`.
- inc/dec arithmetic: edit ±1 with wrap. Hour fields wrap HOUR_MAX↔0; minute and second fields wrap 59↔0.
- `set_val` and `alarm_val` continuously equal the edit register.
- ok in SET_x:
  - Next cycle: the matching `set_hour`/`set_min`/`set_sec` strobe is high for exactly 1 cycle.
  - The state returns to RUN in the same cycle as the strobe.
- ok in AL_HOUR or AL_MIN:
  - `al_hour`/`al_min` takes the edit value.
  - `alarm_set[2]` (AL_HOUR) or `alarm_set[1]` (AL_MIN) pulses for 1 cycle.
  - `alarm_en` is set to 1; the state returns to RUN.
- `alarm_set[0]` is 1 throughout AL_HOUR and AL_MIN, including the strobe cycle; otherwise 0.
- ok in RUN toggles `alarm_en`.
- Ring trigger:
  - Condition: state is RUN, `alarm_en` = 1, `sec_tick` = 1, `cur_hour` = `al_hour`, `cur_min` = `al_min`, `cur_sec` = 0.
  - Response: next state RING, `ring` = 1, ring counter cleared.
  - A trigger that occurs while in any set or alarm state is lost, not deferred.
- In RING:
  - Each `sec_tick` increments the ring counter.
  - Counter reaching RING_SEC → RUN, `ring` = 0.
  - ok → RUN, `ring` = 0 the next cycle; `alarm_en` is unchanged.
  - inc and dec are ignored.
  - mode is treated as dismiss: → RUN, not SET_HOUR.
- Reset mid-operation: immediate return to reset values. Any edit in progress and any strobe in flight are dropped, and the alarm registers return to 0.

Test Plan:
- Reset release → `mode`=0, all strobes 0, `al_hour`=0, `al_min`=0, `ring`=0.
- From RUN with `cur_min`=58: mode ×2, inc ×3, ok → `set_val`=1, `set_min` high for exactly 1 cycle, `mode`=0. Also check `set_hour` and `set_sec` stay 0.
- In SET_HOUR with edit 0: dec → 23; with edit 23: inc → 0. Inc and dec asserted in the same cycle → value unchanged.
- AL_HOUR: set 7, ok → `alarm_set`=3'b101 for 1 cycle, `al_hour`=7, `alarm_en`=1. AL_MIN: set 30, ok → `alarm_set`=3'b011, `al_min`=30.
- Alarm 07:30 armed; drive `cur`=07:30:00 with `sec_tick` → `ring`=1.
  - Let 60 ticks elapse → `ring`=0, `mode`=0.
  - Repeat the trigger, then press ok after 5 ticks → `ring`=0 next cycle, `alarm_en` still 1.
- Assert `rst_n`=0 while in SET_MIN with a pending ok → no `set_min` strobe, all outputs 0 immediately.
